// File: rtl/trap_sequencer.sv
// Interrupt entry/exit sequencer.
// Picks one pending, enabled interrupt and holds fetch until the ROB drains.
// It then raises a single-cycle trap request with cause and EPC. After the
// handler's mret it clears the source at the CLINT and waits for a minimum
// number of commits before it accepts another interrupt.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | armed; watching for an effective interrupt request
//   DRAIN   | fetch held, waiting for the ROB to empty
//   ENTER   | one-cycle trap request with cause/EPC to CSR/PC logic
//   HANDLER | handler running; further interrupts ignored until mret
//   RESUME  | forward-progress window; counting commits before re-arm
module trap_sequencer #(
    parameter int                    PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
    parameter int                    MIN_COMMITS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                csr_mstatus_mie,
    input  logic [2:0]          irq_pending,
    input  logic [2:0]          irq_enable,
    input  logic                rob_empty,
    input  logic                rob_commit_valid,
    input  logic [PC_WIDTH-1:0] rob_commit_pc,
    input  logic                rob_commit_exp,
    input  logic                rob_commit_mret,
    output logic                seq_fetch_hold,
    output logic                seq_flush,
    output logic                trap_req,
    output logic [31:0]         trap_cause,
    output logic [PC_WIDTH-1:0] trap_epc,
    output logic [2:0]          int_clear,
    output logic [2:0]          seq_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_ENTER   = 3'd2,
        ST_HANDLER = 3'd3,
        ST_RESUME  = 3'd4
    } state_t;

    localparam logic [4:0]          MIN_C    = 5'(MIN_COMMITS);
    localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(4);

    state_t              state_q, state_d;
    logic [2:0]          sel_src_q, sel_src_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [PC_WIDTH-1:0] last_pc_q;
    logic [PC_WIDTH-1:0] epc_q;
    logic                epc_load;
    logic                flush_q, flush_d;
    logic [2:0]          int_clear_q, int_clear_d;

    logic [2:0]          eff;
    logic [2:0]          win;
    logic [4:0]          cnt_sum;
    logic [3:0]          cause_code;

    assign eff     = {3{csr_mstatus_mie}} & irq_pending & irq_enable;
    assign cnt_sum = {1'b0, cnt_q} + 5'(rob_commit_valid);

    // Fixed-priority pick: external beats software beats timer.
    always_comb begin
        win = 3'b000;
        if (eff[0]) begin
            win = 3'b001;
        end else if (eff[1]) begin
            win = 3'b010;
        end else if (eff[2]) begin
            win = 3'b100;
        end
    end

    // mcause exception code for the latched source.
    always_comb begin
        cause_code = 4'd0;
        unique case (sel_src_q)
            3'b001:  cause_code = 4'd11;
            3'b010:  cause_code = 4'd3;
            3'b100:  cause_code = 4'd7;
            default: cause_code = 4'd0;
        endcase
    end

    // Next-state, source latch, commit counter and pulse requests.
    always_comb begin
        state_d     = state_q;
        sel_src_d   = sel_src_q;
        cnt_d       = cnt_q;
        flush_d     = 1'b0;
        int_clear_d = 3'b000;
        epc_load    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A committing exception owns the trap; do not start entry.
                if ((eff != 3'b000) && !rob_commit_exp) begin
                    state_d   = ST_DRAIN;
                    sel_src_d = win;
                    flush_d   = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (rob_commit_exp) begin
                    state_d   = ST_IDLE;
                    sel_src_d = 3'b000;
                end else if ((eff & sel_src_q) == 3'b000) begin
                    state_d   = ST_IDLE;
                    sel_src_d = 3'b000;
                end else if (rob_empty) begin
                    state_d  = ST_ENTER;
                    epc_load = 1'b1;
                end
            end
            ST_ENTER: begin
                state_d = ST_HANDLER;
            end
            ST_HANDLER: begin
                // mret wins over a simultaneous exception flag.
                if (rob_commit_mret) begin
                    int_clear_d = sel_src_q;
                    cnt_d       = 4'd0;
                    if (MIN_COMMITS == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RESUME;
                    end
                end
            end
            ST_RESUME: begin
                if (cnt_sum == MIN_C) begin
                    state_d = ST_IDLE;
                end else if (rob_commit_valid) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                sel_src_d = 3'b000;
            end
        endcase
    end

    // FSM state, latched source and commit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_src_q <= 3'b000;
            cnt_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            sel_src_q <= sel_src_d;
            cnt_q     <= cnt_d;
        end
    end

    // Track the PC after the most recent commit; this is the return address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pc_q <= RESET_PC;
        end else if (rob_commit_valid) begin
            last_pc_q <= rob_commit_pc + PC_STEP;
        end
    end

    // Freeze the EPC as the trap is entered so late commits cannot move it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc_q <= '0;
        end else if (epc_load) begin
            epc_q <= last_pc_q;
        end
    end

    // Registered single-cycle flush and CLINT clear pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_q     <= 1'b0;
            int_clear_q <= 3'b000;
        end else begin
            flush_q     <= flush_d;
            int_clear_q <= int_clear_d;
        end
    end

    assign seq_fetch_hold = (state_q == ST_DRAIN) || (state_q == ST_ENTER);
    assign trap_req       = (state_q == ST_ENTER);
    assign trap_cause     = trap_req ? {1'b1, 27'b0, cause_code} : 32'h0;
    assign trap_epc       = trap_req ? epc_q : '0;
    assign seq_flush      = flush_q;
    assign int_clear      = int_clear_q;
    assign seq_state      = state_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed vector table, reset-in-DRAIN sequence,
// then randomized traffic against a behavioural model.
module tb_trap_sequencer;

    localparam int          PW   = 32;
    localparam logic [31:0] RPC  = 32'h0000_1000;
    localparam int          MINC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mie;
    logic [2:0]  pend, en;
    logic        empty, cv, exp_i, mret;
    logic [31:0] pc;

    logic        hold, flush, req;
    logic [31:0] cause, epc;
    logic [2:0]  clr, st;

    trap_sequencer #(.PC_WIDTH(PW), .RESET_PC(RPC), .MIN_COMMITS(MINC)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .csr_mstatus_mie  (mie),
        .irq_pending      (pend),
        .irq_enable       (en),
        .rob_empty        (empty),
        .rob_commit_valid (cv),
        .rob_commit_pc    (pc),
        .rob_commit_exp   (exp_i),
        .rob_commit_mret  (mret),
        .seq_fetch_hold   (hold),
        .seq_flush        (flush),
        .trap_req         (req),
        .trap_cause       (cause),
        .trap_epc         (epc),
        .int_clear        (clr),
        .seq_state        (st)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mie;
        logic [2:0]  en;
        logic [2:0]  pend;
        logic        empty;
        logic        cv;
        logic [31:0] pc;
        logic        exp_i;
        logic        mret;
        logic        hold;
        logic        req;
        logic [31:0] cause;
        logic [31:0] epc;
        logic        flush;
        logic [2:0]  clr;
        logic [2:0]  st;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model: phase numbers follow the published state encoding.
    int          m_phase;
    logic [2:0]  m_sel;
    int          m_code;
    int          m_commits;
    logic [31:0] m_last;
    logic [31:0] m_epc;
    logic        m_flush;
    logic [2:0]  m_clr;
    int          code_tbl[3] = '{11, 3, 7};

    function automatic vec_t mk(logic a_mie, logic [2:0] a_en, logic [2:0] a_pend, logic a_empty,
                                logic a_cv, logic [31:0] a_pc, logic a_exp, logic a_mret,
                                logic e_hold, logic e_req, logic [31:0] e_cause, logic [31:0] e_epc,
                                logic e_flush, logic [2:0] e_clr, logic [2:0] e_st);
        vec_t v;
        v.mie = a_mie; v.en = a_en; v.pend = a_pend; v.empty = a_empty;
        v.cv = a_cv; v.pc = a_pc; v.exp_i = a_exp; v.mret = a_mret;
        v.hold = e_hold; v.req = e_req; v.cause = e_cause; v.epc = e_epc;
        v.flush = e_flush; v.clr = e_clr; v.st = e_st;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_sel = 3'b000; m_code = 0; m_commits = 0;
        m_last = RPC; m_epc = 32'h0; m_flush = 1'b0; m_clr = 3'b000;
    endtask

    // One clock of the model, evaluated from the inputs seen at the edge.
    task automatic model_step();
        logic [2:0]  eff;
        int          n_phase;
        logic        n_flush;
        logic [2:0]  n_clr;
        bit          found;
        eff     = {3{mie}} & pend & en;
        n_phase = m_phase;
        n_flush = 1'b0;
        n_clr   = 3'b000;
        if (m_phase == 0) begin
            if (eff != 0 && !exp_i) begin
                found = 0;
                for (int k = 0; k < 3; k++) begin
                    if (!found && eff[k]) begin
                        found  = 1;
                        m_sel  = 3'(1 << k);
                        m_code = code_tbl[k];
                    end
                end
                n_phase = 1;
                n_flush = 1'b1;
            end
        end else if (m_phase == 1) begin
            if (exp_i) n_phase = 0;
            else if ((eff & m_sel) == 0) n_phase = 0;
            else if (empty) begin
                n_phase = 2;
                m_epc   = m_last;
            end
        end else if (m_phase == 2) begin
            n_phase = 3;
        end else if (m_phase == 3) begin
            if (mret) begin
                n_clr     = m_sel;
                m_commits = 0;
                n_phase   = (MINC == 0) ? 0 : 4;
            end
        end else begin
            if (cv) m_commits++;
            if (m_commits >= MINC) n_phase = 0;
        end
        if (cv) m_last = pc + 32'd4;
        m_phase = n_phase;
        m_flush = n_flush;
        m_clr   = n_clr;
    endtask

    task automatic check_model(string tag);
        logic        e_req;
        logic [31:0] e_cause;
        e_req   = (m_phase == 2);
        e_cause = e_req ? (32'h8000_0000 | 32'(m_code)) : 32'h0;
        chk({tag, ".state"}, 32'(st), 32'(m_phase));
        chk({tag, ".hold"},  32'(hold), 32'(m_phase == 1 || m_phase == 2));
        chk({tag, ".req"},   32'(req), 32'(e_req));
        chk({tag, ".cause"}, cause, e_cause);
        chk({tag, ".epc"},   epc, e_req ? m_epc : 32'h0);
        chk({tag, ".flush"}, 32'(flush), 32'(m_flush));
        chk({tag, ".clr"},   32'(clr), 32'(m_clr));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(logic a_mie, logic [2:0] a_en, logic [2:0] a_pend, logic a_empty,
                         logic a_cv, logic [31:0] a_pc, logic a_exp, logic a_mret);
        mie = a_mie; en = a_en; pend = a_pend; empty = a_empty;
        cv = a_cv; pc = a_pc; exp_i = a_exp; mret = a_mret;
    endtask

    initial begin
        int r;
        string t;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset.state", 32'(st), 32'h0);
        chk("reset.hold",  32'(hold), 32'h0);
        chk("reset.req",   32'(req), 32'h0);
        chk("reset.cause", cause, 32'h0);
        chk("reset.epc",   epc, 32'h0);
        chk("reset.flush", 32'(flush), 32'h0);
        chk("reset.clr",   32'(clr), 32'h0);
        rst_n = 1'b1;

        // single interrupt with empty ROB, then forward-progress window
        tbl.push_back(mk(0,7,0,1, 1,32'h100,0,0, 0,0,32'h0,32'h0,0,3'b000,0));
        tbl.push_back(mk(1,7,2,1, 0,32'h0,0,0,   1,0,32'h0,32'h0,1,3'b000,1));
        tbl.push_back(mk(1,7,2,1, 0,32'h0,0,0,   1,1,32'h80000003,32'h104,0,3'b000,2));
        tbl.push_back(mk(1,7,0,1, 0,32'h0,0,0,   0,0,32'h0,32'h0,0,3'b000,3));
        tbl.push_back(mk(1,7,0,1, 1,32'h300,0,1, 0,0,32'h0,32'h0,0,3'b010,4));
        tbl.push_back(mk(1,7,0,1, 1,32'h304,0,0, 0,0,32'h0,32'h0,0,3'b000,4));
        tbl.push_back(mk(1,7,0,1, 0,32'h0,0,0,   0,0,32'h0,32'h0,0,3'b000,4));
        tbl.push_back(mk(1,7,0,1, 1,32'h308,0,0, 0,0,32'h0,32'h0,0,3'b000,0));
        // priority: all three pending, external wins; held pending ignored in RESUME
        tbl.push_back(mk(1,7,7,1, 0,32'h0,0,0,   1,0,32'h0,32'h0,1,3'b000,1));
        tbl.push_back(mk(1,7,7,1, 0,32'h0,0,0,   1,1,32'h8000000B,32'h30C,0,3'b000,2));
        tbl.push_back(mk(1,7,7,1, 0,32'h0,0,0,   0,0,32'h0,32'h0,0,3'b000,3));
        tbl.push_back(mk(1,7,7,1, 1,32'h400,0,1, 0,0,32'h0,32'h0,0,3'b001,4));
        tbl.push_back(mk(1,7,7,1, 0,32'h0,0,0,   0,0,32'h0,32'h0,0,3'b000,4));
        tbl.push_back(mk(1,7,7,1, 1,32'h404,0,0, 0,0,32'h0,32'h0,0,3'b000,4));
        tbl.push_back(mk(1,7,7,1, 1,32'h408,0,0, 0,0,32'h0,32'h0,0,3'b000,0));
        // exception pre-emption in DRAIN, then withdrawal in DRAIN
        tbl.push_back(mk(1,7,7,1, 0,32'h0,0,0,   1,0,32'h0,32'h0,1,3'b000,1));
        tbl.push_back(mk(1,7,7,1, 1,32'h500,1,0, 0,0,32'h0,32'h0,0,3'b000,0));
        tbl.push_back(mk(1,7,7,0, 0,32'h0,0,0,   1,0,32'h0,32'h0,1,3'b000,1));
        tbl.push_back(mk(1,7,0,0, 0,32'h0,0,0,   0,0,32'h0,32'h0,0,3'b000,0));
        // global mask, exception in IDLE, timer with mret+exp together
        tbl.push_back(mk(0,7,4,1, 0,32'h0,0,0,   0,0,32'h0,32'h0,0,3'b000,0));
        tbl.push_back(mk(1,7,4,1, 1,32'h600,1,0, 0,0,32'h0,32'h0,0,3'b000,0));
        tbl.push_back(mk(1,7,4,1, 0,32'h0,0,0,   1,0,32'h0,32'h0,1,3'b000,1));
        tbl.push_back(mk(1,7,4,1, 0,32'h0,0,0,   1,1,32'h80000007,32'h604,0,3'b000,2));
        tbl.push_back(mk(1,7,4,1, 0,32'h0,0,0,   0,0,32'h0,32'h0,0,3'b000,3));
        tbl.push_back(mk(1,7,4,1, 1,32'h700,1,1, 0,0,32'h0,32'h0,0,3'b100,4));
        tbl.push_back(mk(1,7,4,1, 0,32'h0,0,0,   0,0,32'h0,32'h0,0,3'b000,4));
        tbl.push_back(mk(1,7,4,1, 1,32'h704,0,0, 0,0,32'h0,32'h0,0,3'b000,4));
        tbl.push_back(mk(1,7,4,1, 1,32'h708,0,0, 0,0,32'h0,32'h0,0,3'b000,0));
        tbl.push_back(mk(1,7,4,1, 0,32'h0,0,0,   1,0,32'h0,32'h0,1,3'b000,1));
        tbl.push_back(mk(1,7,0,1, 0,32'h0,0,0,   0,0,32'h0,32'h0,0,3'b000,0));
        // drain wait with commits at 0x200/0x204
        tbl.push_back(mk(1,7,1,0, 0,32'h0,0,0,   1,0,32'h0,32'h0,1,3'b000,1));
        tbl.push_back(mk(1,7,1,0, 1,32'h200,0,0, 1,0,32'h0,32'h0,0,3'b000,1));
        tbl.push_back(mk(1,7,1,0, 1,32'h204,0,0, 1,0,32'h0,32'h0,0,3'b000,1));
        tbl.push_back(mk(1,7,1,0, 0,32'h0,0,0,   1,0,32'h0,32'h0,0,3'b000,1));
        tbl.push_back(mk(1,7,1,0, 0,32'h0,0,0,   1,0,32'h0,32'h0,0,3'b000,1));
        tbl.push_back(mk(1,7,1,1, 0,32'h0,0,0,   1,1,32'h8000000B,32'h208,0,3'b000,2));
        tbl.push_back(mk(1,7,1,1, 0,32'h0,0,0,   0,0,32'h0,32'h0,0,3'b000,3));
        tbl.push_back(mk(1,7,0,1, 1,32'h800,0,1, 0,0,32'h0,32'h0,0,3'b001,4));
        tbl.push_back(mk(1,7,0,1, 1,32'h804,0,0, 0,0,32'h0,32'h0,0,3'b000,4));
        tbl.push_back(mk(1,7,0,1, 1,32'h808,0,0, 0,0,32'h0,32'h0,0,3'b000,0));

        foreach (tbl[i]) begin
            drive(tbl[i].mie, tbl[i].en, tbl[i].pend, tbl[i].empty,
                  tbl[i].cv, tbl[i].pc, tbl[i].exp_i, tbl[i].mret);
            step();
            t = $sformatf("tbl[%0d]", i);
            chk({t, ".state"}, 32'(st), 32'(tbl[i].st));
            chk({t, ".hold"},  32'(hold), 32'(tbl[i].hold));
            chk({t, ".req"},   32'(req), 32'(tbl[i].req));
            chk({t, ".cause"}, cause, tbl[i].cause);
            chk({t, ".epc"},   epc, tbl[i].epc);
            chk({t, ".flush"}, 32'(flush), 32'(tbl[i].flush));
            chk({t, ".clr"},   32'(clr), 32'(tbl[i].clr));
        end

        // asynchronous reset in the middle of DRAIN
        drive(1, 7, 1, 0, 0, 0, 0, 0);
        step();
        check_model("pre_rst");
        #2 rst_n = 1'b0;
        #1;
        chk("rst.state", 32'(st), 32'h0);
        chk("rst.hold",  32'(hold), 32'h0);
        chk("rst.req",   32'(req), 32'h0);
        chk("rst.flush", 32'(flush), 32'h0);
        chk("rst.clr",   32'(clr), 32'h0);
        chk("rst.epc",   epc, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 7, 2, 1, 0, 0, 0, 0);
        step(); check_model("post_rst0");
        step(); check_model("post_rst1");
        chk("rst.epc_tracker", epc, RPC);
        step(); check_model("post_rst2");
        drive(1, 7, 0, 1, 1, 32'h900, 0, 1);
        step(); check_model("post_rst3");

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            r     = int'($urandom_range(0, 99));
            mie   = (r < 90);
            pend  = ($urandom_range(0, 2) == 0) ? 3'($urandom()) : 3'b000;
            en    = ($urandom_range(0, 3) == 0) ? 3'($urandom()) : 3'b111;
            empty = 1'($urandom());
            cv    = 1'($urandom());
            pc    = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
            exp_i = ($urandom_range(0, 19) == 0);
            mret  = ($urandom_range(0, 9) == 0);
            step();
            check_model($sformatf("rnd[%0d]", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
